// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache request adapter.
package cache_pkg;

  localparam int TAG_W    = 20;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic       op;
    logic [1:0] addr_lo;
    logic [1:0] size;
    logic       unsgn;
    logic       cancel;
  } req_info_t;

  // size 3 is reserved and behaves as a word
  function automatic logic [31:0] load_extract(
    input logic [31:0] rd,
    input logic [1:0]  lo,
    input logic [1:0]  size,
    input logic        unsgn
  );
    logic [31:0] sh;
    logic        sx;
    sh = rd;
    sx = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: begin
        sh = rd >> {lo, 3'b000};
        sx = ~unsgn & sh[7];
        sh = {{24{sx}}, sh[7:0]};
      end
      size == SZ_HALF: begin
        sh = rd >> {lo[1], 4'b0000};
        sx = ~unsgn & sh[15];
        sh = {{16{sx}}, sh[15:0]};
      end
      default: sh = rd;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/cache_req_adapter_fifo.sv
// In-order FIFO of outstanding request descriptors.
// cancel_all marks every resident entry so its response is dropped.
module req_info_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  req_info_t              push_data,
  input  logic                   pop,
  input  logic                   cancel_all,
  output req_info_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  req_info_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   cnt_q;

  assign head  = mem_q[rptr_q];
  assign full  = cnt_q == DEPTH[PW:0];
  assign empty = cnt_q == '0;
  assign count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (cancel_all)
        for (int i = 0; i < DEPTH; i++)
          mem_q[i].cancel <= 1'b1;
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop)
        rptr_q <= rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + ONE;
        2'b01:   cnt_q <= cnt_q - ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cache_req_adapter.sv
// MEM-stage to data-cache request adapter with in-order response alignment.
// Optional CACHE_REQ_FLUSH_EN adds a flush input that cancels in-flight responses.
module cache_req_adapter
  import cache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic                req_op,
  input  logic [31:0]         req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_wdata,
  output logic                req_ready,
  output logic                resp_valid,
  output logic                resp_op,
  output logic [31:0]         resp_rdata,
  output logic                valid,
  output logic                op,
  output logic [TAG_W-1:0]    tag,
  output logic [INDEX_W-1:0]  index,
  output logic [OFFSET_W-1:0] offset,
  output logic [3:0]          wstrb,
  output logic [31:0]         wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
`ifdef CACHE_REQ_FLUSH_EN
  input  logic                flush,
`endif
  input  logic [31:0]         rdata
);

  logic      is_half;
  logic      is_word;
  logic      misal;
  logic      flush_w;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  req_info_t head;
  req_info_t entry;
  logic [$clog2(DEPTH):0] fifo_count_unused;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_op_q, resp_op_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

`ifdef CACHE_REQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign is_half = req_size == SZ_HALF;
  assign is_word = req_size[1];
  assign misal   = (is_half & req_addr[0])
                 | (is_word & |req_addr[1:0]);

  // misaligned requests are swallowed; the pipeline raises ALE
  assign valid     = req_valid & ~misal & ~full & ~flush_w;
  assign req_ready = ~flush_w
                   & ((valid & addr_ok) | (req_valid & misal));

  assign op     = req_op;
  assign tag    = req_addr[31:12];
  assign index  = req_addr[11:4];
  assign offset = req_addr[3:0];

  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    if (req_op) begin
      unique case (1'b1)
        is_word: begin
          wstrb = 4'b1111;
          wdata = req_wdata;
        end
        is_half: begin
          wstrb = 4'b0011 << {req_addr[1], 1'b0};
          wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          wstrb = 4'b0001 << req_addr[1:0];
          wdata = {4{req_wdata[7:0]}};
        end
      endcase
    end
  end

  assign push  = valid & addr_ok;
  assign pop   = data_ok & ~empty;
  assign entry = '{op:      req_op,
                   addr_lo: req_addr[1:0],
                   size:    req_size,
                   unsgn:   req_unsigned,
                   cancel:  1'b0};

  req_info_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (resetn),
    .push       (push),
    .push_data  (entry),
    .pop        (pop),
    .cancel_all (flush_w),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (fifo_count_unused)
  );

  always_comb begin
    resp_valid_d = pop & ~head.cancel & ~flush_w;
    resp_op_d    = resp_op_q;
    resp_rdata_d = resp_rdata_q;
    if (pop) begin
      resp_op_d    = head.op;
      resp_rdata_d = head.op ? '0
                   : load_extract(rdata, head.addr_lo,
                                  head.size, head.unsgn);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_op_q    <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_op_q    <= resp_op_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_op    = resp_op_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_cache_req_adapter.sv
// Scoreboard bench for cache_req_adapter: random traffic vs. a queue model.
// Define CACHE_REQ_FLUSH_EN to also exercise flush.
module tb_cache_req_adapter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_op, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, resp_op;
  logic [31:0] resp_rdata;
  logic        valid, op;
  logic [19:0] tag;
  logic [7:0]  index;
  logic [3:0]  offset, wstrb;
  logic [31:0] wdata, rdata;
  logic        addr_ok, data_ok;
`ifdef CACHE_REQ_FLUSH_EN
  logic        flush;
`endif

  cache_req_adapter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_op(resp_op), .resp_rdata(resp_rdata),
    .valid(valid), .op(op), .tag(tag), .index(index),
    .offset(offset), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok),
`ifdef CACHE_REQ_FLUSH_EN
    .flush(flush),
`endif
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit op;
    int lo;
    int nb;
    bit uns;
    bit cancel;
  } pend_t;

  typedef struct {
    int          due;
    bit          op;
    logic [31:0] data;
  } exp_t;

  pend_t pend[$];
  exp_t  expq[$];
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ext(logic [31:0] rd, int lo,
                                      int nb, bit uns);
    longint v;
    v = longint'(rd >> (8 * lo));
    v = v % (longint'(1) << (8 * nb));
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  // monitor: response due this cycle, or none at all
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        exp_t e;
        e = expq.pop_front();
        chk("resp_valid", resp_valid, 1);
        chk("resp_op", resp_op, e.op);
        chk("resp_rdata", resp_rdata, e.data);
      end else begin
        chk("resp_idle", resp_valid, 0);
      end
    end
  end

  task automatic step(bit rv, bit rop, logic [31:0] a,
                      logic [1:0] sz, bit uns, logic [31:0] wd,
                      bit aok, bit dok, logic [31:0] rd, bit fl);
    int lo, nb;
    bit aligned, ev, er;
    logic [3:0]  es;
    logic [31:0] ew;
    @(posedge clk);
    #1;
    req_valid = rv; req_op = rop; req_addr = a;
    req_size = sz; req_unsigned = uns; req_wdata = wd;
    addr_ok = aok; data_ok = dok; rdata = rd;
`ifdef CACHE_REQ_FLUSH_EN
    flush = fl;
`endif
    #1;
    lo = int'(a[1:0]);
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    aligned = (lo % nb) == 0;
    ev = rv && aligned && pend.size() < DEPTH && !fl;
    er = !fl && ((ev && aok) || (rv && !aligned));
    chk("valid", valid, ev);
    chk("req_ready", req_ready, er);
    if (ev) begin
      chk("tag", tag, a[31:12]);
      chk("index", index, a[11:4]);
      chk("offset", offset, a[3:0]);
      chk("op", op, rop);
    end
    if (aligned) begin
      es = '0;
      ew = '0;
      for (int b = 0; b < 4; b++) begin
        if (rop && b >= lo && b < lo + nb) es[b] = 1'b1;
        if (rop) ew[8*b +: 8] = wd[8*(b % nb) +: 8];
      end
      chk("wstrb", wstrb, es);
      chk("wdata", wdata, ew);
    end
    if (dok && pend.size() > 0) begin
      pend_t p;
      p = pend.pop_front();
      if (!(p.cancel || fl))
        expq.push_back('{cyc + 1, p.op,
                         p.op ? 32'd0 : ext(rd, p.lo, p.nb, p.uns)});
    end
    if (fl)
      foreach (pend[i]) pend[i].cancel = 1;
    if (ev && aok)
      pend.push_back('{rop, lo, nb, uns, 0});
  endtask

  task automatic idle(bit dok, logic [31:0] rd);
    step(0, 0, 0, 0, 0, 0, 0, dok, rd, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 0;
    req_valid = 0; addr_ok = 0; data_ok = 0;
`ifdef CACHE_REQ_FLUSH_EN
    flush = 0;
`endif
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_op", resp_op, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    pend.delete();
    expq.delete();
    @(posedge clk);
    #1;
    resetn = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    req_valid = 0; req_op = 0; req_addr = 0; req_size = 0;
    req_unsigned = 0; req_wdata = 0;
    addr_ok = 0; data_ok = 0; rdata = 0;
`ifdef CACHE_REQ_FLUSH_EN
    flush = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("init_resp_valid", resp_valid, 0);
    chk("init_resp_op", resp_op, 0);
    chk("init_resp_rdata", resp_rdata, 0);
    resetn = 1;

    // word load, then data
    step(1, 0, 32'h1C00_0010, 2, 0, 0, 1, 0, 0, 0);
    idle(1, 32'hDEAD_BEEF);
    // byte store with replication
    step(1, 1, 32'h0000_0003, 0, 0, 32'hA5, 1, 0, 0, 0);
    idle(1, 32'h1234_5678);
    // signed / unsigned byte at offset 2
    step(1, 0, 32'h0000_0002, 0, 0, 0, 1, 0, 0, 0);
    idle(1, 32'h0080_0000);
    step(1, 0, 32'h0000_0002, 0, 1, 0, 1, 0, 0, 0);
    idle(1, 32'h0080_0000);
    // fill to DEPTH, then push/pop overlap
    step(1, 0, 32'h0000_0100, 2, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h0000_0104, 1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h0000_0108, 0, 1, 0, 1, 0, 0, 0);
    step(1, 0, 32'h0000_0108, 0, 1, 0, 1, 1, 32'h1111_2222, 0);
    step(1, 0, 32'h0000_0108, 0, 1, 0, 1, 1, 32'h3333_4444, 0);
    idle(1, 32'hF0F1_F2F3);
    idle(1, 32'hAAAA_AAAA);
    // misaligned half, data_ok while empty
    step(1, 0, 32'h0000_0201, 1, 0, 0, 1, 0, 0, 0);
    idle(1, 32'h5555_5555);
    idle(0, 0);
`ifdef CACHE_REQ_FLUSH_EN
    step(1, 0, 32'h0000_0300, 2, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h0000_0304, 2, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h0000_0308, 2, 0, 0, 1, 0, 0, 1);
    idle(1, 32'h0BAD_0BAD);
    idle(1, 32'h0BAD_0BAD);
    step(1, 0, 32'h0000_030C, 2, 0, 0, 1, 0, 0, 0);
    idle(1, 32'h600D_600D);
`endif
    // reset mid-flight, then stray data_ok
    step(1, 0, 32'h0000_0400, 2, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h0000_0404, 2, 0, 0, 1, 0, 0, 0);
    do_reset();
    idle(1, 32'h9999_9999);
    idle(0, 0);

    for (int n = 0; n < 3000; n++) begin
      bit fl;
      fl = 0;
`ifdef CACHE_REQ_FLUSH_EN
      fl = ($urandom_range(0, 29) == 0);
`endif
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1),
           $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 1),
           $urandom, fl);
    end

    for (int n = 0; n < DEPTH + 2; n++)
      idle(1, $urandom);
    repeat (3) idle(0, 0);
    chk("expq_drained", expq.size(), 0);
    chk("pend_drained", pend.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
